psum_collector: RTL and testbench

// Sits at the bottom of each systolic-array column and receives the partial-sum stream leaving the last PE: Psum, Addr_P and Valid_P.
// It overwrites or accumulates each sum into a local ADDR_W-addressed accumulator RAM, using saturating arithmetic.
// On command, it drains a window of that RAM to the output buffer over a valid/ready handshake.
// It is the receiving end of the PE psum chain; the array cannot stall, so the write path never back-pressures.

---
 rtl/psum_collector.sv | 233 +++++++++++++++++++++++
 tb/tb_psum_collector.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_collector.sv
// -----------------------------------------------------------------------------
// psum_collector
// Receives the partial-sum stream that leaves the bottom PE of a systolic-array
// column. Each sum is either written over an entry of a local accumulator RAM or
// added to it with saturation. On command, a window of the RAM is drained to the
// output buffer over a valid/ready handshake.
//
// The array cannot stall, so the write path never back-pressures. It is a
// two-stage pipeline:
//   S1: register Psum/Addr/Valid and read RAM[Addr]. When S2 is writing the
//       same entry in that cycle, S2's result is forwarded instead of the RAM
//       data.
//   S2: compute the new value and write it to the RAM.
//
// Ports
//   CLK          clock, all logic on posedge
//   RST_N        asynchronous active-low reset
//   Psum_In      partial sum from the bottom PE (signed, BIT_PSUM)
//   Addr_P_In    target entry for Psum_In
//   Valid_P_In   [0] write enable, [1] accumulate (1) / overwrite (0)
//   Drain_Start  one-cycle pulse that starts a drain (ignored while busy)
//   Drain_Base   first entry to drain, sampled on Drain_Start
//   Drain_Len    number of entries to drain (0..DEPTH), sampled on Drain_Start
//   Out_Data     drained value (signed, ACC_W)
//   Out_Addr     entry index of Out_Data
//   Out_Valid    Out_Data/Out_Addr valid; held stable until Out_Ready
//   Out_Ready    downstream accepts the beat when Out_Valid & Out_Ready
//   Drain_Busy   drain in progress
//   Drain_Done   one-cycle pulse after the last beat is accepted
//   Ovf_Flag     sticky flag: saturation has occurred since reset
// -----------------------------------------------------------------------------
module psum_collector #(
    parameter int BIT_PSUM  = 32,
    parameter int ACC_W     = 32,
    parameter int ADDR_W    = 9,
    parameter int BIT_VALID = 2,
    parameter bit CLR_ON_RD = 1'b1
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic signed [BIT_PSUM-1:0]  Psum_In,
    input  logic        [ADDR_W-1:0]    Addr_P_In,
    input  logic        [BIT_VALID-1:0] Valid_P_In,
    input  logic                        Drain_Start,
    input  logic        [ADDR_W-1:0]    Drain_Base,
    input  logic        [ADDR_W:0]      Drain_Len,
    output logic signed [ACC_W-1:0]     Out_Data,
    output logic        [ADDR_W-1:0]    Out_Addr,
    output logic                        Out_Valid,
    input  logic                        Out_Ready,
    output logic                        Drain_Busy,
    output logic                        Drain_Done,
    output logic                        Ovf_Flag
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_OUT  = 2'd2,
        ST_DONE = 2'd3
    } drain_state_t;

    // Saturating add. Bit ACC_W of the result flags a clamp; the low ACC_W bits
    // hold the (possibly clamped) sum. One guard bit is enough to detect
    // overflow because ACC_W >= BIT_PSUM.
    function automatic logic [ACC_W:0] sat_add(
        input logic signed [ACC_W-1:0]    a,
        input logic signed [BIT_PSUM-1:0] b
    );
        logic signed [ACC_W:0] sum;
        logic        [ACC_W:0] res;
        sum = (ACC_W+1)'(a) + (ACC_W+1)'(b);
        if (sum[ACC_W] != sum[ACC_W-1]) begin
            if (sum[ACC_W]) begin
                res = {1'b1, 1'b1, {(ACC_W-1){1'b0}}};
            end else begin
                res = {1'b1, 1'b0, {(ACC_W-1){1'b1}}};
            end
        end else begin
            res = {1'b0, sum[ACC_W-1:0]};
        end
        return res;
    endfunction

    // Accumulator storage (deliberately not reset)
    logic signed [ACC_W-1:0]    acc_mem_r [DEPTH];

    // Write pipeline, S2 stage registers
    logic                       s2_valid_r;
    logic                       s2_acc_r;
    logic        [ADDR_W-1:0]   s2_addr_r;
    logic signed [BIT_PSUM-1:0] s2_psum_r;
    logic signed [ACC_W-1:0]    s2_old_r;
    logic signed [ACC_W-1:0]    new_s;
    logic                       clamp_s;
    logic        [ACC_W:0]      sat_s;
    logic                       fwd_s;
    logic                       ovf_r;

    // Drain machinery
    drain_state_t               state_r;
    drain_state_t               state_next_s;
    logic        [ADDR_W-1:0]   ptr_r;
    logic        [ADDR_W:0]     cnt_r;
    logic                       accept_s;
    logic                       clr_wr_s;
    logic signed [ACC_W-1:0]    out_data_r;
    logic        [ADDR_W-1:0]   out_addr_r;
    logic                       out_valid_r;
    logic                       busy_r;
    logic                       done_r;

    // S2 datapath: overwrite with the sign-extended psum, or saturating accumulate
    always_comb begin
        sat_s = sat_add(s2_old_r, s2_psum_r);
        if (s2_acc_r) begin
            new_s   = sat_s[ACC_W-1:0];
            clamp_s = sat_s[ACC_W];
        end else begin
            new_s   = ACC_W'(s2_psum_r);
            clamp_s = 1'b0;
        end
    end

    // S1 read must see the value S2 is writing in the same cycle
    assign fwd_s = s2_valid_r && (Addr_P_In == s2_addr_r);

    // Write-pipeline control registers and the sticky overflow flag
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s2_valid_r <= 1'b0;
            s2_acc_r   <= 1'b0;
            s2_addr_r  <= '0;
            s2_psum_r  <= '0;
            ovf_r      <= 1'b0;
        end else begin
            s2_valid_r <= Valid_P_In[0];
            s2_acc_r   <= Valid_P_In[1];
            s2_addr_r  <= Addr_P_In;
            s2_psum_r  <= Psum_In;
            if (s2_valid_r && clamp_s) begin
                ovf_r <= 1'b1;
            end
        end
    end

    // Accumulator RAM: drain clear port, psum write port (listed last so it
    // wins a same-entry collision) and the S1 read with forwarding
    always_ff @(posedge CLK) begin
        if (clr_wr_s) begin
            acc_mem_r[ptr_r] <= '0;
        end
        if (s2_valid_r) begin
            acc_mem_r[s2_addr_r] <= new_s;
        end
        s2_old_r <= fwd_s ? new_s : acc_mem_r[Addr_P_In];
    end

    // A beat is accepted only while presenting it in OUT
    assign accept_s = (state_r == ST_OUT) && Out_Ready;
    assign clr_wr_s = accept_s && CLR_ON_RD;

    // Drain FSM next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (Drain_Start) begin
                    state_next_s = (Drain_Len == '0) ? ST_DONE : ST_RD;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RD: begin
                state_next_s = ST_OUT;
            end
            ST_OUT: begin
                if (accept_s) begin
                    state_next_s = (cnt_r == (ADDR_W+1)'(1)) ? ST_DONE : ST_RD;
                end else begin
                    state_next_s = ST_OUT;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Drain FSM state, window pointer/count and registered drain outputs
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r     <= ST_IDLE;
            ptr_r       <= '0;
            cnt_r       <= '0;
            out_data_r  <= '0;
            out_addr_r  <= '0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if ((state_r == ST_IDLE) && Drain_Start) begin
                ptr_r <= Drain_Base;
                cnt_r <= Drain_Len;
            end else if (accept_s) begin
                // pointer wraps naturally past DEPTH-1
                ptr_r <= ptr_r + ADDR_W'(1);
                cnt_r <= cnt_r - (ADDR_W+1)'(1);
            end
            if (state_r == ST_RD) begin
                out_data_r <= acc_mem_r[ptr_r];
                out_addr_r <= ptr_r;
            end
            out_valid_r <= (state_next_s == ST_OUT);
            busy_r      <= (state_next_s != ST_IDLE);
            done_r      <= (state_next_s == ST_DONE);
        end
    end

    assign Out_Data   = out_data_r;
    assign Out_Addr   = out_addr_r;
    assign Out_Valid  = out_valid_r;
    assign Drain_Busy = busy_r;
    assign Drain_Done = done_r;
    assign Ovf_Flag   = ovf_r;

endmodule

// File: tb/tb_psum_collector.sv
// -----------------------------------------------------------------------------
// tb_psum_collector
// Directed bench for psum_collector: overwrite/accumulate, back-to-back
// forwarding, positive and negative saturation, wrapping drain with stalls,
// clear-on-read, zero-length drain, Drain_Start while busy, and reset mid-drain.
// Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_psum_collector;

    logic        CLK;
    logic        RST_N;
    logic [31:0] Psum_In;
    logic [8:0]  Addr_P_In;
    logic [1:0]  Valid_P_In;
    logic        Drain_Start;
    logic [8:0]  Drain_Base;
    logic [9:0]  Drain_Len;
    logic [31:0] Out_Data;
    logic [8:0]  Out_Addr;
    logic        Out_Valid;
    logic        Out_Ready;
    logic        Drain_Busy;
    logic        Drain_Done;
    logic        Ovf_Flag;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q [$];

    psum_collector #(
        .BIT_PSUM (32),
        .ACC_W    (32),
        .ADDR_W   (9),
        .BIT_VALID(2),
        .CLR_ON_RD(1'b1)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .Psum_In    (Psum_In),
        .Addr_P_In  (Addr_P_In),
        .Valid_P_In (Valid_P_In),
        .Drain_Start(Drain_Start),
        .Drain_Base (Drain_Base),
        .Drain_Len  (Drain_Len),
        .Out_Data   (Out_Data),
        .Out_Addr   (Out_Addr),
        .Out_Valid  (Out_Valid),
        .Out_Ready  (Out_Ready),
        .Drain_Busy (Drain_Busy),
        .Drain_Done (Drain_Done),
        .Ovf_Flag   (Ovf_Flag)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] p, input logic [8:0] a, input logic [1:0] v);
        Psum_In    = p;
        Addr_P_In  = a;
        Valid_P_In = v;
        step();
    endtask

    task automatic flush();
        Valid_P_In = 2'b00;
        step();
        step();
    endtask

    // Drain a window of len>0 entries; expected data comes from exp_q.
    task automatic drain_run(input logic [8:0] base, input logic [9:0] len, input bit stall, input string tag);
        int  beat;
        int  cyc;
        int  done_cnt;
        bit  stalled;
        bit  accepted;
        Drain_Start = 1'b1;
        Drain_Base  = base;
        Drain_Len   = len;
        Out_Ready   = 1'b0;
        step();
        Drain_Start = 1'b0;
        check({tag, "_busy_rd"}, 64'(Drain_Busy), 64'd1);
        check({tag, "_nvalid_rd"}, 64'(Out_Valid), 64'd0);
        step();
        check({tag, "_first_valid"}, 64'(Out_Valid), 64'd1);
        beat = 0;
        done_cnt = 0;
        stalled = 1'b0;
        for (cyc = 0; cyc < 200; cyc++) begin
            if (Drain_Done) begin
                done_cnt++;
                break;
            end
            if (Out_Valid) begin
                check({tag, "_addr"}, 64'(Out_Addr), 64'((int'(base) + beat) % 512));
                check({tag, "_data"}, 64'(Out_Data), 64'(exp_q[beat]));
            end
            if (Out_Valid && stall && !stalled) begin
                Out_Ready = 1'b0;
                stalled   = 1'b1;
            end else begin
                Out_Ready = 1'b1;
            end
            // a start pulse while busy must be ignored
            Drain_Start = (cyc == 0);
            Drain_Base  = base + 9'd100;
            Drain_Len   = 10'd1;
            accepted = Out_Valid && Out_Ready;
            step();
            if (accepted) begin
                beat++;
                stalled = 1'b0;
            end
        end
        Drain_Start = 1'b0;
        Out_Ready   = 1'b0;
        check({tag, "_done_seen"}, 64'(done_cnt), 64'd1);
        check({tag, "_beats"}, 64'(beat), 64'(len));
        step();
        check({tag, "_done_pulse"}, 64'(Drain_Done), 64'd0);
        check({tag, "_idle"}, 64'(Drain_Busy), 64'd0);
    endtask

    initial begin
        RST_N       = 1'b0;
        Psum_In     = 32'd0;
        Addr_P_In   = 9'd0;
        Valid_P_In  = 2'b00;
        Drain_Start = 1'b0;
        Drain_Base  = 9'd0;
        Drain_Len   = 10'd0;
        Out_Ready   = 1'b0;
        step();
        step();
        check("rst_valid", 64'(Out_Valid), 64'd0);
        check("rst_busy", 64'(Drain_Busy), 64'd0);
        check("rst_done", 64'(Drain_Done), 64'd0);
        check("rst_ovf", 64'(Ovf_Flag), 64'd0);
        check("rst_data", 64'(Out_Data), 64'd0);
        check("rst_addr", 64'(Out_Addr), 64'd0);
        RST_N = 1'b1;
        step();

        // overwrite 5 then accumulate -2 back-to-back; V=10 must be a no-op
        wr(32'd5, 9'd3, 2'b01);
        wr(32'hFFFF_FFFE, 9'd3, 2'b11);
        wr(32'd99, 9'd3, 2'b10);
        flush();
        exp_q = '{32'd3};
        drain_run(9'd3, 10'd1, 1'b0, "ovr_acc");

        // four back-to-back accumulates after overwrite 0
        wr(32'd0, 9'd10, 2'b01);
        wr(32'd7, 9'd10, 2'b11);
        wr(32'd7, 9'd10, 2'b11);
        wr(32'd7, 9'd10, 2'b11);
        wr(32'd7, 9'd10, 2'b11);
        flush();
        exp_q = '{32'd28};
        drain_run(9'd10, 10'd1, 1'b0, "fwd");
        check("ovf_before_sat", 64'(Ovf_Flag), 64'd0);

        // positive saturation
        wr(32'h7FFF_FFF0, 9'd20, 2'b01);
        wr(32'h0000_0100, 9'd20, 2'b11);
        flush();
        check("ovf_set", 64'(Ovf_Flag), 64'd1);
        exp_q = '{32'h7FFF_FFFF};
        drain_run(9'd20, 10'd1, 1'b0, "sat_pos");

        // negative saturation
        wr(32'h8000_0010, 9'd21, 2'b01);
        wr(32'hFFFF_FF00, 9'd21, 2'b11);
        flush();
        exp_q = '{32'h8000_0000};
        drain_run(9'd21, 10'd1, 1'b0, "sat_neg");

        // wrapping drain with a one-cycle stall on every beat
        wr(32'd11, 9'd510, 2'b01);
        wr(32'd12, 9'd511, 2'b01);
        wr(32'd13, 9'd0, 2'b01);
        wr(32'd14, 9'd1, 2'b01);
        flush();
        exp_q = '{32'd11, 32'd12, 32'd13, 32'd14};
        drain_run(9'd510, 10'd4, 1'b1, "wrap");

        // entries 0 and 1 were cleared by the previous drain
        exp_q = '{32'd0, 32'd0};
        drain_run(9'd0, 10'd2, 1'b0, "clr");

        // zero-length drain: Done one cycle after start, no Out_Valid
        Drain_Start = 1'b1;
        Drain_Base  = 9'd5;
        Drain_Len   = 10'd0;
        step();
        Drain_Start = 1'b0;
        check("len0_done", 64'(Drain_Done), 64'd1);
        check("len0_nvalid", 64'(Out_Valid), 64'd0);
        step();
        check("len0_done_end", 64'(Drain_Done), 64'd0);
        check("len0_nvalid2", 64'(Out_Valid), 64'd0);
        check("len0_idle", 64'(Drain_Busy), 64'd0);

        // reset during OUT of a 4-beat drain
        wr(32'd100, 9'd40, 2'b01);
        wr(32'd101, 9'd41, 2'b01);
        wr(32'd102, 9'd42, 2'b01);
        wr(32'd103, 9'd43, 2'b01);
        flush();
        Drain_Start = 1'b1;
        Drain_Base  = 9'd40;
        Drain_Len   = 10'd4;
        Out_Ready   = 1'b0;
        step();
        Drain_Start = 1'b0;
        step();
        check("mid_valid", 64'(Out_Valid), 64'd1);
        RST_N = 1'b0;
        #1;
        check("mid_rst_valid", 64'(Out_Valid), 64'd0);
        check("mid_rst_busy", 64'(Drain_Busy), 64'd0);
        check("mid_rst_data", 64'(Out_Data), 64'd0);
        step();
        check("mid_rst_done", 64'(Drain_Done), 64'd0);
        check("ovf_cleared_by_rst", 64'(Ovf_Flag), 64'd0);
        RST_N = 1'b1;
        step();
        check("post_rst_done", 64'(Drain_Done), 64'd0);
        exp_q = '{32'd100, 32'd101, 32'd102, 32'd103};
        drain_run(9'd40, 10'd4, 1'b0, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
